// File: rtl/pe_pkg.sv
// Shared types and helpers for the output-stationary MAC processing element.
// Provides the FSM state encoding, operand-mode constants and a width-generic saturating adder.
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pe_state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Widest accumulator sat_add can handle; operands live in the low w bits.
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Adds two w-bit values in w+1 bits, checking the signed or unsigned range
  // according to mode; on overflow clamps when sat=1, otherwise wraps.
  function automatic sat_res_t sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int                   w,
    input logic                 mode,
    input logic                 sat
  );
    logic [SAT_MAX_W:0] mask;
    logic [SAT_MAX_W:0] smax;
    logic [SAT_MAX_W:0] xa;
    logic [SAT_MAX_W:0] xb;
    logic [SAT_MAX_W:0] s;
    sat_res_t           r;
    mask = {(SAT_MAX_W+1){1'b1}} >> (SAT_MAX_W + 1 - w);
    smax = mask >> 1;
    xa   = {1'b0, a} & mask;
    xb   = {1'b0, b} & mask;
    if (mode && a[w-1]) xa = xa | ~mask;
    if (mode && b[w-1]) xb = xb | ~mask;
    s     = xa + xb;
    r.ovf = mode ? (s[w] != s[w-1]) : s[w];
    r.sum = s[SAT_MAX_W-1:0] & mask[SAT_MAX_W-1:0];
    if (r.ovf && sat) begin
      if (!mode)     r.sum = mask[SAT_MAX_W-1:0];
      else if (s[w]) r.sum = mask[SAT_MAX_W-1:0] & ~smax[SAT_MAX_W-1:0];
      else           r.sum = smax[SAT_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// Pipelined DATA_W x DATA_W multiplier carrying valid and signed mode with the product.
// Latency MUL_LAT cycles, one operand pair per cycle, never stalls.
module pe_mul_pipe
  import pe_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic                  in_mode,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  output logic                  out_vld,
  output logic                  out_mode,
  output logic [2*DATA_W-1:0]   out_prod,
  output logic                  busy
);

  logic signed [DATA_W:0]     ext_a;
  logic signed [DATA_W:0]     ext_b;
  logic signed [2*DATA_W-1:0] prod;

  logic [MUL_LAT-1:0]   vld_q;
  logic [MUL_LAT-1:0]   mode_q;
  logic [2*DATA_W-1:0]  prod_q [MUL_LAT];

  // One extra bit lets a single signed multiplier serve both modes; the low
  // 2*DATA_W bits are exact for either interpretation.
  assign ext_a = {in_mode & in_a[DATA_W-1], in_a};
  assign ext_b = {in_mode & in_b[DATA_W-1], in_b};
  assign prod  = ext_a * ext_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      if (in_vld) begin
        mode_q[0] <= in_mode;
        prod_q[0] <= prod;
      end
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          mode_q[i] <= mode_q[i-1];
          prod_q[i] <= prod_q[i-1];
        end
      end
    end
  end

  assign out_vld  = vld_q[MUL_LAT-1];
  assign out_mode = mode_q[MUL_LAT-1];
  assign out_prod = prod_q[MUL_LAT-1];
  assign busy     = |vld_q;

endmodule

// File: rtl/pe_mac.sv
// Output-stationary MAC PE: forwards operands east/south (1 cycle), accumulates products,
// drains one result MUL_LAT+2 cycles after drain; no backpressure, operands in FLUSH/DONE are not accumulated.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int MUL_LAT = 2,
  parameter int SAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_vld,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_vld,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              pe_en,
  input  logic              signed_mode,
  input  logic              acc_clr,
  input  logic              drain,
  output logic              out0_vld,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_vld,
  output logic [DATA_W-1:0] out1_data,
  output logic              pe_doing,
  output logic              res_vld,
  output logic [ACC_W-1:0]  res_data,
  output logic              ovf
);

  localparam int              CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

  pe_state_t            state;
  pe_state_t            state_nxt;
  logic [CNT_W-1:0]     flush_cnt;
  logic                 flush_last;
  logic                 fire;

  logic                 p_vld;
  logic                 p_mode;
  logic [2*DATA_W-1:0]  p_prod;
  logic                 mul_busy;

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_base;
  logic [ACC_W-1:0]     acc_nxt;
  logic [ACC_W-1:0]     prod_ext;
  logic                 ovf_nxt;
  sat_res_t             add_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_vld  <= 1'b0;
      out1_vld  <= 1'b0;
      out0_data <= '0;
      out1_data <= '0;
    end else begin
      out0_vld <= in0_vld;
      out1_vld <= in1_vld;
      if (in0_vld) out0_data <= in0_data;
      if (in1_vld) out1_data <= in1_data;
    end
  end

  assign fire = in0_vld & in1_vld & pe_en & (state != ST_FLUSH) & (state != ST_DONE);

  pe_mul_pipe #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (fire),
    .in_mode  (signed_mode),
    .in_a     (in0_data),
    .in_b     (in1_data),
    .out_vld  (p_vld),
    .out_mode (p_mode),
    .out_prod (p_prod),
    .busy     (mul_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (drain) state_nxt = ST_FLUSH;
                else if (fire) state_nxt = ST_ACC;
      ST_ACC:   if (drain) state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    res_vld  = (state == ST_DONE);
    pe_doing = (state != ST_IDLE) | mul_busy;
  end

  // FLUSH spans MUL_LAT+1 cycles so a fire taken with the drain still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                flush_cnt <= '0;
    else if (state != ST_FLUSH) flush_cnt <= '0;
    else                        flush_cnt <= flush_cnt + 1'b1;
  end

  assign flush_last = (state == ST_FLUSH) && (flush_cnt == CNT_LAST);

  assign prod_ext = p_mode ? ACC_W'($signed(p_prod)) : ACC_W'(p_prod);
  assign acc_base = acc_clr ? '0 : acc;
  assign add_res  = sat_add(SAT_MAX_W'(acc_base), SAT_MAX_W'(prod_ext), ACC_W, p_mode, SAT != 0);

  generate
    if (ACC_W < SAT_MAX_W) begin : g_sum_hi
      logic unused_sum_hi;
      assign unused_sum_hi = ^add_res.sum[SAT_MAX_W-1:ACC_W];
    end
  endgenerate

  // Clear applies before a same-cycle product; DONE empties the PE for the next tile.
  always_comb begin
    acc_nxt = acc_base;
    ovf_nxt = acc_clr ? 1'b0 : ovf;
    if (p_vld) begin
      acc_nxt = add_res.sum[ACC_W-1:0];
      ovf_nxt = ovf_nxt | add_res.ovf;
    end
    if (state == ST_DONE) begin
      acc_nxt = '0;
      ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      ovf      <= 1'b0;
      res_data <= '0;
    end else begin
      acc <= acc_nxt;
      ovf <= ovf_nxt;
      if (flush_last) res_data <= acc_nxt;
    end
  end

endmodule
